barrel_shifter_32: RTL and testbench



---
 rtl/barrel_shifter_32.sv | 62 ++++++
 tb/tb_barrel_shifter_32.sv | 122 ++++++++++++
 2 files changed

// File: rtl/barrel_shifter_32.sv
// 32-bit registered barrel shifter: five log-structured mux stages (1/2/4/8/16)
// selected by b[k], direction/fill from aluc, result registered on c.

module bs_stage #(
    parameter int SH = 1
) (
    input  logic [31:0] d_i,
    input  logic        en_i,
    input  logic        left_i,
    input  logic        fill_i,
    output logic [31:0] q_o
);
    logic [31:0] shl;
    logic [31:0] shr;

    assign shl = {d_i[31-SH:0], {SH{1'b0}}};
    assign shr = {{SH{fill_i}}, d_i[31:SH]};

    always_comb begin
        q_o = d_i;
        if (en_i) q_o = left_i ? shl : shr;
    end
endmodule

module barrel_shifter_32 (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] a,
    input  logic [4:0]  b,
    input  logic [1:0]  aluc,
    output logic [31:0] c
);
    logic [5:0][31:0] stg;
    logic             left;
    logic             fill;
    logic [31:0]      c_d;
    logic [31:0]      c_q;

    // fill comes from the original sign bit so every stage sees the same value
    assign left   = aluc[1];
    assign fill   = ~aluc[0] & a[31];
    assign stg[0] = a;

    for (genvar k = 0; k < 5; k++) begin : g_stage
        bs_stage #(.SH(1 << k)) u_stage (
            .d_i    (stg[k]),
            .en_i   (b[k]),
            .left_i (left),
            .fill_i (fill),
            .q_o    (stg[k+1])
        );
    end

    assign c_d = stg[5];

    always_ff @(posedge clk) begin
        if (rst) c_q <= 32'h0000_0000;
        else     c_q <= c_d;
    end

    assign c = c_q;
endmodule

// File: tb/tb_barrel_shifter_32.sv
// Self-checking bench for barrel_shifter_32: directed test-plan values, a full
// aluc x b sweep with a mid-stream reset, and randomized traffic vs a reference.

module tb_barrel_shifter_32;
    logic        clk;
    logic        rst;
    logic [31:0] a;
    logic [4:0]  b;
    logic [1:0]  aluc;
    logic [31:0] c;

    int errors = 0;
    int checks = 0;

    localparam logic [31:0] A0 = 32'hA5F0C3E7;

    barrel_shifter_32 dut (
        .clk  (clk),
        .rst  (rst),
        .a    (a),
        .b    (b),
        .aluc (aluc),
        .c    (c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_shift(input logic [31:0] av, input logic [4:0] bv,
                                              input logic [1:0] op);
        logic signed [31:0] sa;
        sa = av;
        case (op)
            2'b00:   return 32'(sa >>> bv);
            2'b01:   return av >> bv;
            default: return av << bv;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // drive inputs just after an edge, then sample one edge later
    task automatic drive(input logic r, input logic [1:0] op, input logic [4:0] bv,
                         input logic [31:0] av);
        rst = r; aluc = op; b = bv; a = av;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input string tag, input logic [1:0] op, input logic [4:0] bv,
                       input logic [31:0] exp);
        drive(1'b0, op, bv, A0);
        tick();
        chk(tag, c, exp);
    endtask

    logic [31:0] ra;
    logic [4:0]  rb;
    logic [1:0]  rop;
    logic        rr;

    initial begin
        drive(1'b1, 2'b11, 5'd7, 32'hDEAD_BEEF);
        tick();
        drive(1'b1, 2'b00, 5'd3, A0);
        tick();
        chk("reset", c, 32'h0);

        run("release_b0", 2'b01, 5'd0, A0);

        run("sra_4",  2'b00, 5'd4,  32'hFA5F0C3E);
        run("sra_16", 2'b00, 5'd16, 32'hFFFFA5F0);
        run("sra_31", 2'b00, 5'd31, 32'hFFFFFFFF);
        run("srl_4",  2'b01, 5'd4,  32'h0A5F0C3E);
        run("srl_16", 2'b01, 5'd16, 32'h0000A5F0);
        run("srl_31", 2'b01, 5'd31, 32'h00000001);
        for (int op = 2; op < 4; op++) begin
            run("sl_4",  2'(op), 5'd4,  32'h5F0C3E70);
            run("sl_8",  2'(op), 5'd8,  32'hF0C3E700);
            run("sl_31", 2'(op), 5'd31, 32'h80000000);
        end

        // full sweep, with a one-cycle reset dropped in the middle
        for (int op = 0; op < 4; op++) begin
            for (int bv = 0; bv < 32; bv++) begin
                if (op == 2 && bv == 10) begin
                    drive(1'b1, 2'(op), 5'(bv), A0);
                    tick();
                    chk("sweep_rst", c, 32'h0);
                end
                drive(1'b0, 2'(op), 5'(bv), A0);
                tick();
                chk("sweep", c, ref_shift(A0, 5'(bv), 2'(op)));
                if (bv == 0) chk("sweep_b0", c, A0);
            end
        end

        // random traffic, including occasional resets and sign-heavy operands
        for (int i = 0; i < 400; i++) begin
            ra  = $urandom;
            if (i % 4 == 0) ra[31] = 1'b1;
            rb  = 5'($urandom_range(0, 31));
            rop = 2'($urandom_range(0, 3));
            rr  = ($urandom_range(0, 15) == 0);
            drive(rr, rop, rb, ra);
            tick();
            chk(rr ? "rand_rst" : "rand", c, rr ? 32'h0 : ref_shift(ra, rb, rop));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
